// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN inference pipeline.
// Used by the sequencer and the sibling datapath blocks.
package cnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_IM2COL = 3'd2,
    ST_CONV   = 3'd3,
    ST_FC     = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam int unsigned CNT_W_DEF   = 24;
  localparam int unsigned TIMEOUT_DEF = 200000;

  localparam int unsigned IMG_DIM  = 28;
  localparam int unsigned KER_DIM  = 3;
  localparam int unsigned CONV_LEN = 676;
  localparam int unsigned FC_OUT   = 10;

  function automatic logic is_stage(state_e s);
    return (s == ST_IM2COL) ||
           (s == ST_CONV) ||
           (s == ST_FC);
  endfunction

endpackage

// File: rtl/cnn_seq_timer.sv
// Clear/enable up-counter that saturates at LIMIT.
// hit_o flags the saturated value.
module cnn_seq_timer #(
  parameter int unsigned    W     = 24,
  parameter logic [W-1:0]   LIMIT = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         hit_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign hit_o = (cnt_q == LIMIT);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !hit_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cnn_seq_ctrl.sv
// Job sequencer: capture -> Im2Col -> conv -> FC, with cycle count.
// Optional stage watchdog enabled by defining CNN_SEQ_WATCHDOG_EN.
module cnn_seq_ctrl
  import cnn_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vld_i,
  output logic             rdy_o,
  output logic             load_en_o,
  output logic             im2col_start_o,
  input  logic             im2col_done_i,
  output logic             conv_start_o,
  input  logic             conv_done_i,
  output logic             fc_start_o,
  input  logic             fc_done_i,
  output logic             done_o,
  output logic             busy_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic             err_o
);

  state_e state_q, state_d;
  logic   first_q, first_d;
  logic   accept;
  logic   cyc_sat;
  logic   wd_hit;

  assign rdy_o     = (state_q == ST_IDLE);
  assign accept    = vld_i & rdy_o;
  assign load_en_o = accept;
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign state_o   = state_q;

  // first_q marks the entry cycle of a state: start pulse out, done ignored
  assign im2col_start_o = first_q && (state_q == ST_IM2COL);
  assign conv_start_o   = first_q && (state_q == ST_CONV);
  assign fc_start_o     = first_q && (state_q == ST_FC);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_IM2COL;
      end
      ST_IM2COL: begin
        if (!first_q && im2col_done_i) state_d = ST_CONV;
        else if (wd_hit)               state_d = ST_ERR;
      end
      ST_CONV: begin
        if (!first_q && conv_done_i) state_d = ST_FC;
        else if (wd_hit)             state_d = ST_ERR;
      end
      ST_FC: begin
        if (!first_q && fc_done_i) state_d = ST_DONE;
        else if (wd_hit)           state_d = ST_ERR;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    first_d = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  cnn_seq_timer #(
    .W     (CNT_W),
    .LIMIT ({CNT_W{1'b1}})
  ) u_cyc_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (accept),
    .en_i  (busy_o && (state_q != ST_ERR) && !cyc_sat),
    .cnt_o (cycle_cnt_o),
    .hit_o (cyc_sat)
  );

`ifdef CNN_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] wd_cnt;

  // Timer reads 0 in a stage's first cycle; hit one cycle before TIMEOUT
  // so ERR is entered exactly TIMEOUT cycles after the start pulse.
  cnn_seq_timer #(
    .W     (WD_W),
    .LIMIT (WD_W'(TIMEOUT - 1))
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .clr_i (first_d),
    .en_i  (is_stage(state_q)),
    .cnt_o (wd_cnt),
    .hit_o (wd_hit)
  );

  assign err_o = (state_q == ST_ERR);
`else
  assign wd_hit = 1'b0;
  assign err_o  = 1'b0;
`endif

endmodule
